// File: rtl/dmem_resp_if.sv
// Pipeline-side load/store request and response bundle of the data-memory responder.
// master = MEM stage, slave = dmem_resp.
interface dmem_resp_if;
  logic        req_cs_en;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        hold_req;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  modport master (
    output req_cs_en, req_wen, req_size, req_addr, req_wdata, flush,
    input  hold_req, rsp_valid, rsp_rdata, misalign_err
  );

  modport slave (
    input  req_cs_en, req_wen, req_size, req_addr, req_wdata, flush,
    output hold_req, rsp_valid, rsp_rdata, misalign_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time into a byte-lane synchronous SRAM with WAIT_CYCLES latency.
// Optional misalignment check enabled by defining DMEM_RESP_MISALIGN_CHK_EN.
module dmem_resp #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_resp_if.slave        bus,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 32'sd0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 32'sd1) : 4'd0;

  function automatic logic [3:0] lane_be(input logic wen, input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    if (!wen) begin
      be = 4'b1111;
    end else begin
      case (size)
        2'b00:   be = 4'b0001 << a;
        2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic wen, input logic [1:0] size, input logic [31:0] d);
    logic [31:0] wd;
    if (!wen) begin
      wd = d;
    end else begin
      case (size)
        2'b00:   wd = {4{d[7:0]}};
        2'b01:   wd = {2{d[15:0]}};
        default: wd = d;
      endcase
    end
    return wd;
  endfunction

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction
`endif

  state_t              state_r;
  state_t              state_s;
  logic                hold_s;
  logic                accept_s;
  logic                mis_s;
  logic [3:0]          cnt_r;
  logic                wen_r;
  logic                mis_r;
  logic                rsp_valid_r;
  logic [31:0]         hold_data_r;
  logic [31:0]         rsp_rdata_s;
  logic                sram_ce_r;
  logic                sram_we_r;
  logic [3:0]          sram_be_r;
  logic [ADDR_W-1:0]   sram_addr_r;
  logic [31:0]         sram_wdata_r;
  logic                unused_s;

  assign unused_s = ^bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  logic misalign_err_r;
  assign mis_s            = is_misaligned(bus.req_size, bus.req_addr[1:0]);
  assign bus.misalign_err = misalign_err_r;
`else
  assign mis_s            = 1'b0;
  assign bus.misalign_err = 1'b0;
`endif

  // Next-state and stall decode; a request is only taken from IDLE.
  always_comb begin
    state_s  = state_r;
    hold_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hold_s = bus.req_cs_en & ~bus.flush;
        if (hold_s) begin
          accept_s = 1'b1;
          if (mis_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_ACCESS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        hold_s = 1'b1;
        if (HAS_WAIT) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_RESP;
        end
      end
      ST_WAIT: begin
        hold_s = 1'b1;
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, wait counter, latched request kind, response strobe and load-data hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      wen_r       <= 1'b0;
      mis_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      hold_data_r <= 32'd0;
    end else begin
      state_r     <= state_s;
      rsp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        wen_r <= bus.req_wen;
        mis_r <= mis_s;
      end
      if (state_r == ST_ACCESS) begin
        cnt_r <= WAIT_LOAD;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if ((state_r == ST_RESP) && !wen_r && !mis_r) begin
        hold_data_r <= sram_rdata;
      end
    end
  end

`ifdef DMEM_RESP_MISALIGN_CHK_EN
  // Misalignment flag rides along with the RESP strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err_r <= 1'b0;
    end else begin
      misalign_err_r <= accept_s & mis_s;
    end
  end
`endif

  // SRAM drive is loaded on acceptance so it is valid exactly in the ACCESS cycle, zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_ce_r    <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_be_r    <= 4'd0;
      sram_addr_r  <= '0;
      sram_wdata_r <= 32'd0;
    end else if (accept_s && !mis_s) begin
      sram_ce_r    <= 1'b1;
      sram_we_r    <= bus.req_wen;
      sram_be_r    <= lane_be(bus.req_wen, bus.req_size, bus.req_addr[1:0]);
      sram_addr_r  <= bus.req_addr[ADDR_W+1:2];
      sram_wdata_r <= lane_wdata(bus.req_wen, bus.req_size, bus.req_wdata);
    end else begin
      sram_ce_r    <= 1'b0;
      sram_we_r    <= 1'b0;
      sram_be_r    <= 4'd0;
      sram_addr_r  <= '0;
      sram_wdata_r <= 32'd0;
    end
  end

  // Load data is passed straight through in RESP; otherwise the last loaded word is shown.
  always_comb begin
    rsp_rdata_s = hold_data_r;
    if (state_r == ST_RESP) begin
      if (mis_r) begin
        rsp_rdata_s = 32'd0;
      end else if (!wen_r) begin
        rsp_rdata_s = sram_rdata;
      end else begin
        rsp_rdata_s = hold_data_r;
      end
    end else begin
      rsp_rdata_s = hold_data_r;
    end
  end

  assign bus.hold_req  = hold_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_s;
  assign sram_ce       = sram_ce_r;
  assign sram_we       = sram_we_r;
  assign sram_be       = sram_be_r;
  assign sram_addr     = sram_addr_r;
  assign sram_wdata    = sram_wdata_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized bench for dmem_resp: three instances (WAIT_CYCLES 1, 0, 3), each with its own SRAM model,
// checked cycle by cycle against a transaction-level reference model.
module tb_dmem_resp;
  localparam int NI = 3;
  localparam int AW = 14;

  logic          clk;
  logic          rst;
  logic          cs_en      [NI];
  logic          wen        [NI];
  logic [1:0]    size       [NI];
  logic [31:0]   addr       [NI];
  logic [31:0]   wdata      [NI];
  logic          flush      [NI];
  logic [31:0]   sram_rdata [NI];
  logic          o_hold     [NI];
  logic          o_valid    [NI];
  logic [31:0]   o_rdata    [NI];
  logic          o_mis      [NI];
  logic          o_ce       [NI];
  logic          o_we       [NI];
  logic [3:0]    o_be       [NI];
  logic [AW-1:0] o_addr     [NI];
  logic [31:0]   o_wdata    [NI];

  logic [31:0] ref_mem [NI][16];
  logic [31:0] hold_m  [NI];
  logic [31:0] smem    [NI][16];
  int          pend    [NI];
  logic [3:0]  lat     [NI];
  int          n_cmp;
  int          n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WG = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    dmem_resp_if bus ();
    assign bus.req_cs_en = cs_en[g];
    assign bus.req_wen   = wen[g];
    assign bus.req_size  = size[g];
    assign bus.req_addr  = addr[g];
    assign bus.req_wdata = wdata[g];
    assign bus.flush     = flush[g];
    assign o_hold[g]     = bus.hold_req;
    assign o_valid[g]    = bus.rsp_valid;
    assign o_rdata[g]    = bus.rsp_rdata;
    assign o_mis[g]      = bus.misalign_err;
    dmem_resp #(.ADDR_W(AW), .WAIT_CYCLES(WG)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_ce    (o_ce[g]),
      .sram_we    (o_we[g]),
      .sram_be    (o_be[g]),
      .sram_addr  (o_addr[g]),
      .sram_wdata (o_wdata[g]),
      .sram_rdata (sram_rdata[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic logic [51:0] sram_vec(input int k);
    return {o_ce[k], o_we[k], o_be[k], o_addr[k], o_wdata[k]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM model: data appears only in the cycle WAIT_CYCLES+1 after the chip-enable cycle, noise otherwise.
  initial begin
    for (int k = 0; k < NI; k++) begin
      pend[k] = 0;
      lat[k]  = 4'd0;
      sram_rdata[k] = $urandom;
      for (int w = 0; w < 16; w++) smem[k][w] = 32'd0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
        sram_rdata[k] = $urandom;
        if (o_ce[k] === 1'b1) begin
          lat[k] = o_addr[k][3:0];
          if (o_we[k]) begin
            for (int l = 0; l < 4; l++)
              if (o_be[k][l]) smem[k][lat[k]][8*l +: 8] = o_wdata[k][8*l +: 8];
          end
          pend[k] = wc(k) + 1;
        end else if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0) sram_rdata[k] = smem[k][lat[k]];
        end
      end
    end
  end

  task automatic check_quiet(input int k, input string tag);
    check_eq({tag, " hold"}, 64'(o_hold[k]), 64'd0);
    check_eq({tag, " valid"}, 64'(o_valid[k]), 64'd0);
    check_eq({tag, " sram"}, 64'(sram_vec(k)), 64'd0);
    check_eq({tag, " rdata"}, 64'(o_rdata[k]), 64'(hold_m[k]));
    check_eq({tag, " mis"}, 64'(o_mis[k]), 64'd0);
  endtask

  // Entered and left at posedge+1; one request issued at the first cycle and followed to its RESP.
  task automatic do_req(input int k, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit flush_busy);
    int          nb, ab, widx, r;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wd, word, exp_rd;
    logic [51:0] exp_vec;
    nb   = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    ab   = int'(a[5:0]);
    widx = ab / 4;
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    mis = (ab % nb) != 0;
`else
    mis = 1'b0;
`endif
    word = ref_mem[k][widx];
    for (int l = 0; l < 4; l++) begin
      be[l] = !w || ((l / nb) == ((ab % 4) / nb));
      wd[8*l +: 8] = w ? d[8*(l % nb) +: 8] : d[8*l +: 8];
    end
    exp_vec = mis ? 52'd0 : {1'b1, w, be, a[AW+1:2], wd};
    r       = mis ? 1 : 2 + wc(k);
    exp_rd  = mis ? 32'd0 : (w ? hold_m[k] : word);
    cs_en[k] = 1'b1;
    wen[k]   = w;
    size[k]  = sz;
    addr[k]  = a;
    wdata[k] = d;
    flush[k] = 1'b0;
    for (int i = 0; i <= r; i++) begin
      @(negedge clk);
      check_eq($sformatf("hold k%0d a%0h c%0d", k, a, i), 64'(o_hold[k]), 64'(i < r));
      check_eq($sformatf("valid k%0d a%0h c%0d", k, a, i), 64'(o_valid[k]), 64'(i == r));
      check_eq($sformatf("sram k%0d a%0h c%0d", k, a, i), 64'(sram_vec(k)), (i == 1) ? 64'(exp_vec) : 64'd0);
      check_eq($sformatf("rdata k%0d a%0h c%0d", k, a, i), 64'(o_rdata[k]), (i == r) ? 64'(exp_rd) : 64'(hold_m[k]));
      check_eq($sformatf("mis k%0d a%0h c%0d", k, a, i), 64'(o_mis[k]), 64'((i == r) && mis));
      @(posedge clk);
      #1;
      if (flush_busy) flush[k] = 1'b1;
    end
    cs_en[k] = 1'b0;
    flush[k] = 1'b0;
    if (!mis) begin
      if (w) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) ref_mem[k][widx][8*l +: 8] = wd[8*l +: 8];
      end else begin
        hold_m[k] = word;
      end
    end
  endtask

  // Idle cycles, optionally with a request present but flushed (must never be accepted).
  task automatic idle_cycles(input int k, input int n, input bit fl);
    cs_en[k] = fl;
    flush[k] = fl;
    addr[k]  = 32'h0000_0010;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_quiet(k, $sformatf("idle k%0d fl%0d c%0d", k, fl, i));
      @(posedge clk);
      #1;
    end
    cs_en[k] = 1'b0;
    flush[k] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int k = 0; k < NI; k++) begin
      cs_en[k] = 1'b0;
      wen[k]   = 1'b0;
      size[k]  = 2'b00;
      addr[k]  = 32'd0;
      wdata[k] = 32'd0;
      flush[k] = 1'b0;
      hold_m[k] = 32'd0;
      for (int w = 0; w < 16; w++) ref_mem[k][w] = 32'd0;
    end
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) check_quiet(k, $sformatf("reset k%0d", k));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases on the WAIT_CYCLES=1 instance.
    do_req(0, 1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0000_0000, 1'b0);
    do_req(0, 1'b1, 2'b00, 32'h0000_0013, 32'h0000_00A5, 1'b0);
    do_req(0, 1'b1, 2'b01, 32'h0000_0006, 32'h0000_1234, 1'b0);
    do_req(0, 1'b0, 2'b10, 32'h0000_0002, 32'h0000_0000, 1'b0);
    idle_cycles(0, 3, 1'b1);
    do_req(0, 1'b1, 2'b10, 32'h0000_0008, 32'h0BAD_F00D, 1'b1);
    do_req(0, 1'b0, 2'b10, 32'h0000_0010, 32'h0000_0000, 1'b1);

    // Reset asserted while a load sits in WAIT.
    cs_en[0] = 1'b1;
    wen[0]   = 1'b0;
    size[0]  = 2'b10;
    addr[0]  = 32'h0000_0008;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("pre-rst hold", 64'(o_hold[0]), 64'd1);
    check_eq("pre-rst ce", 64'(o_ce[0]), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst sram", 64'(sram_vec(0)), 64'd0);
    check_eq("rst valid", 64'(o_valid[0]), 64'd0);
    check_eq("rst rdata", 64'(o_rdata[0]), 64'd0);
    check_eq("rst mis", 64'(o_mis[0]), 64'd0);
    check_eq("rst hold req present", 64'(o_hold[0]), 64'd1);
    cs_en[0] = 1'b0;
    #1;
    check_eq("rst hold no req", 64'(o_hold[0]), 64'd0);
    for (int k = 0; k < NI; k++) hold_m[k] = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(0, 1, 1'b0);

    // Directed WAIT_CYCLES=0 case, then randomized traffic on every instance.
    do_req(1, 1'b1, 2'b10, 32'h0000_0004, 32'h1357_9BDF, 1'b0);
    do_req(1, 1'b0, 2'b10, 32'h0000_0004, 32'h0000_0000, 1'b0);
    for (int k = 0; k < NI; k++) begin
      repeat (30) begin
        do_req(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)),
               $urandom, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 2) == 0)
          idle_cycles(k, int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
